// File: rtl/bky_shift_ctrl_pkg.sv
// Shared definitions for the Buckeye shift-chain controller: state encoding and chip constants.
package bky_shift_ctrl_pkg;

  localparam int unsigned NBITS_DEF = 48;
  localparam int unsigned NCHIPS    = 6;
  localparam logic [NCHIPS-1:0] MASK_DEF = 6'b111111;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLow,
    StHigh,
    StFin
  } state_e;

endpackage

// File: rtl/bky_lane.sv
// One Buckeye chip lane: working shift register, DOUT capture and gated AMPIN/AMPCLK flops.
module bky_lane
  import bky_shift_ctrl_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned BW    = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             en_in,
  input  logic [NBITS-1:0] din,
  input  logic             shift,
  input  logic             sample,
  input  logic [BW-1:0]    bit_idx,
  input  logic             amp_out,
  input  logic             drive,
  input  logic             clk_hi,
  output logic             amp_in,
  output logic             amp_clk,
  output logic [NBITS-1:0] dout
);

  logic             en_q;
  logic [NBITS-1:0] work_q, work_d;

  always_comb begin
    work_d = work_q;
    if (load) begin
      work_d = din;
    end else if (shift) begin
      work_d = work_q >> 1;
    end
  end

  // drive/clk_hi describe the next cycle, so AMPIN/AMPCLK come straight off flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_q    <= 1'b0;
      work_q  <= '0;
      dout    <= '0;
      amp_in  <= 1'b0;
      amp_clk <= 1'b0;
    end else begin
      work_q  <= work_d;
      amp_in  <= drive & en_q & work_d[0];
      amp_clk <= clk_hi & en_q;
      if (load) begin
        en_q <= en_in;
        dout <= '0;
      end else if (sample && en_q) begin
        dout[bit_idx] <= amp_out;
      end
    end
  end

endmodule

// File: rtl/bky_shift_ctrl.sv
// Buckeye shift controller: sequences NBITS clocked shifts into six chips and captures the return data.
module bky_shift_ctrl
  import bky_shift_ctrl_pkg::*;
#(
  parameter int unsigned NBITS   = NBITS_DEF,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [NCHIPS-1:0]       MASK,
  input  logic [NCHIPS*NBITS-1:0] DIN,
  input  logic [NCHIPS-1:0]       AMPOUT,
  output logic [NCHIPS-1:0]       AMPIN,
  output logic [NCHIPS-1:0]       AMPCLK,
  output logic [NCHIPS*NBITS-1:0] DOUT,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned PW = $clog2(CLK_DIV) + 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            phase_last, bit_last;
  logic            load, sample, shift, drive_d, clk_hi_d, busy_d, done_d;

  assign phase_last = (phase_q == PW'(CLK_DIV - 1));
  assign bit_last   = (bit_q == BW'(NBITS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      bit_q   <= '0;
      phase_q <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    unique case (state_q)
      StIdle: if (START) state_d = StLoad;
      StLoad: begin
        state_d = StLow;
        bit_d   = '0;
        phase_d = '0;
      end
      StLow: begin
        if (phase_last) begin
          state_d = StHigh;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StHigh: begin
        if (phase_last) begin
          phase_d = '0;
          bit_d   = bit_q + 1'b1;
          state_d = bit_last ? StFin : StLow;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes act on the current edge; *_d levels are what the output flops show next cycle.
  always_comb begin
    load     = (state_q == StIdle) && START;
    sample   = (state_q == StLow) && phase_last;
    shift    = (state_q == StHigh) && phase_last;
    drive_d  = (state_d == StLow) || (state_d == StHigh);
    clk_hi_d = (state_d == StHigh);
    busy_d   = (state_d == StLoad) || (state_d == StLow) || (state_d == StHigh);
    done_d   = (state_d == StFin);
  end

  for (genvar g = 0; g < NCHIPS; g++) begin : g_lane
    bky_lane #(
      .NBITS(NBITS),
      .BW   (BW)
    ) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .load   (load),
      .en_in  (MASK[g]),
      .din    (DIN[g*NBITS +: NBITS]),
      .shift  (shift),
      .sample (sample),
      .bit_idx(bit_q),
      .amp_out(AMPOUT[g]),
      .drive  (drive_d),
      .clk_hi (clk_hi_d),
      .amp_in (AMPIN[g]),
      .amp_clk(AMPCLK[g]),
      .dout   (DOUT[g*NBITS +: NBITS])
    );
  end

endmodule

// File: tb/tb_bky_shift_ctrl.sv
// Bench for bky_shift_ctrl: two instances (CLK_DIV 4 and 1) driving behavioural Buckeye chip models.
module tb_bky_shift_ctrl;
  import bky_shift_ctrl_pkg::*;

  localparam int NB = 48;
  localparam int NC = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start_r  [2];
  logic [NC-1:0]    mask_r   [2];
  logic [NC*NB-1:0] din_r    [2];
  logic [NC-1:0]    ampout_w [2];
  logic [NC-1:0]    ampin_w  [2];
  logic [NC-1:0]    ampclk_w [2];
  logic [NC*NB-1:0] dout_w   [2];
  logic             busy_w   [2];
  logic             done_w   [2];

  bky_shift_ctrl #(.NBITS(NB), .CLK_DIV(4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start_r[0]), .MASK(mask_r[0]), .DIN(din_r[0]),
    .AMPOUT(ampout_w[0]), .AMPIN(ampin_w[0]), .AMPCLK(ampclk_w[0]), .DOUT(dout_w[0]),
    .BUSY(busy_w[0]), .DONE(done_w[0])
  );

  bky_shift_ctrl #(.NBITS(NB), .CLK_DIV(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start_r[1]), .MASK(mask_r[1]), .DIN(din_r[1]),
    .AMPOUT(ampout_w[1]), .AMPIN(ampin_w[1]), .AMPCLK(ampclk_w[1]), .DOUT(dout_w[1]),
    .BUSY(busy_w[1]), .DONE(done_w[1])
  );

  // Chip models: shift right on each AMPCLK rise, AMPIN into the MSB, AMPOUT is bit 0.
  logic [NB-1:0] m        [2][NC];
  int            e        [2][NC];
  logic [NC-1:0] clk_prev [2];
  logic          mdl_clr, cnt_clr;
  logic [NB-1:0] exp_chip [2][NC];
  int            n_cmp = 0;
  int            n_bad = 0;

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < NC; n++) begin
        if (mdl_clr) m[s][n] <= '0;
        else if (ampclk_w[s][n] && !clk_prev[s][n]) m[s][n] <= {ampin_w[s][n], m[s][n][NB-1:1]};
        if (cnt_clr) e[s][n] <= 0;
        else if (ampclk_w[s][n] && !clk_prev[s][n]) e[s][n] <= e[s][n] + 1;
      end
      clk_prev[s] <= ampclk_w[s];
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ampout_w[s] = '0;
      for (int n = 0; n < NC; n++) ampout_w[s][n] = m[s][n][0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*NB-1:0] rand_din();
    logic [NC*NB-1:0] r;
    for (int n = 0; n < NC; n++) r[n*NB +: NB] = NB'({$urandom, $urandom});
    return r;
  endfunction

  // One full shift on instance sel; extra START pulses at cycles ra/rb must be ignored.
  task automatic run_shift(input int sel, input logic [NC-1:0] mask, input logic [NC*NB-1:0] din,
                           input int ra, input int rb);
    int            cd;
    int            n_exp;
    int            done_cyc;
    int            done_cnt;
    int            busy_bad;
    logic [NB-1:0] exp_dout [NC];
    logic [NB-1:0] exp_mdl  [NC];
    cd       = (sel == 0) ? 4 : 1;
    n_exp    = 2 + 2 * cd * NB;
    done_cyc = -1;
    done_cnt = 0;
    busy_bad = 0;
    for (int n = 0; n < NC; n++) begin
      exp_dout[n] = mask[n] ? exp_chip[sel][n] : '0;
      exp_mdl[n]  = mask[n] ? din[n*NB +: NB] : exp_chip[sel][n];
    end
    din_r[sel]   = din;
    mask_r[sel]  = mask;
    start_r[sel] = 1'b1;
    cnt_clr      = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int c = 1; c <= n_exp + 4; c++) begin
      if (done_w[sel]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy_w[sel] !== (c < n_exp)) busy_bad++;
      start_r[sel] = (c == ra) || (c == rb);
      tick();
    end
    start_r[sel] = 1'b0;
    n_cmp++;
    if (done_cyc !== n_exp) begin
      n_bad++;
      $display("FAIL latency[%0d]: got %0d want %0d", sel, done_cyc, n_exp);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL done_pulses[%0d]: got %0d want 1", sel, done_cnt);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_bad++;
      $display("FAIL busy_window[%0d]: got %0d bad cycles want 0", sel, busy_bad);
    end
    for (int n = 0; n < NC; n++) begin
      n_cmp++;
      if (dout_w[sel][n*NB +: NB] !== exp_dout[n]) begin
        n_bad++;
        $display("FAIL dout[%0d][%0d]: got %h want %h", sel, n, dout_w[sel][n*NB +: NB], exp_dout[n]);
      end
      n_cmp++;
      if (m[sel][n] !== exp_mdl[n]) begin
        n_bad++;
        $display("FAIL chip_model[%0d][%0d]: got %h want %h", sel, n, m[sel][n], exp_mdl[n]);
      end
      n_cmp++;
      if (e[sel][n] !== (mask[n] ? NB : 0)) begin
        n_bad++;
        $display("FAIL ampclk_edges[%0d][%0d]: got %0d want %0d", sel, n, e[sel][n],
                 mask[n] ? NB : 0);
      end
      exp_chip[sel][n] = exp_mdl[n];
    end
  endtask

  task automatic check_idle_outputs(input int sel, input string tag);
    n_cmp++;
    if ({ampin_w[sel], ampclk_w[sel], busy_w[sel], done_w[sel]} !== '0) begin
      n_bad++;
      $display("FAIL %s_ctrl[%0d]: got ampin=%b ampclk=%b busy=%b done=%b want all 0", tag, sel,
               ampin_w[sel], ampclk_w[sel], busy_w[sel], done_w[sel]);
    end
    n_cmp++;
    if (dout_w[sel] !== '0) begin
      n_bad++;
      $display("FAIL %s_dout[%0d]: got %h want 0", tag, sel, dout_w[sel]);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    mdl_clr = 1'b1;
    cnt_clr = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_r[s] = 1'b0;
      mask_r[s]  = '0;
      din_r[s]   = '0;
      for (int n = 0; n < NC; n++) exp_chip[s][n] = '0;
    end
    repeat (3) tick();
    for (int s = 0; s < 2; s++) check_idle_outputs(s, "reset");
    mdl_clr = 1'b0;
    cnt_clr = 1'b0;
    rst     = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) check_idle_outputs(s, "post_reset");
  endtask

  task automatic test_all_chips();
    logic [NC*NB-1:0] d;
    for (int n = 0; n < NC; n++) d[n*NB +: NB] = 48'hA5A5_0000_0000 + NB'(n);
    run_shift(0, 6'b111111, d, -1, -1);
  endtask

  task automatic test_repeat_zero();
    run_shift(0, 6'b111111, '0, -1, -1);
  endtask

  // Chips 2, 4, 6 (indices 1, 3, 5) disabled.
  task automatic test_partial_mask();
    run_shift(0, 6'b010101, rand_din(), -1, -1);
  endtask

  task automatic test_start_ignored();
    run_shift(0, 6'b111111, rand_din(), 100, 2 + 2 * 4 * NB);
  endtask

  task automatic test_mask_zero();
    run_shift(1, 6'b000000, rand_din(), -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      run_shift((i == 2) ? 0 : 1, 6'($urandom_range(0, 63)), rand_din(), -1, -1);
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    int seen_busy;
    seen_done   = 0;
    seen_busy   = 0;
    din_r[0]    = rand_din();
    mask_r[0]   = 6'b111111;
    start_r[0]  = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (199) tick();
    rst = 1'b1;
    #1;
    check_idle_outputs(0, "abort");
    repeat (3) begin
      tick();
      if (done_w[0]) seen_done++;
    end
    rst = 1'b0;
    repeat (10) begin
      tick();
      if (done_w[0]) seen_done++;
      if (busy_w[0]) seen_busy++;
    end
    n_cmp++;
    if (seen_done !== 0 || seen_busy !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got done=%0d busy=%0d cycles want 0", seen_done, seen_busy);
    end
    mdl_clr = 1'b1;
    tick();
    mdl_clr = 1'b0;
    for (int s = 0; s < 2; s++) for (int n = 0; n < NC; n++) exp_chip[s][n] = '0;
    run_shift(1, 6'b111111, rand_din(), -1, -1);
    run_shift(1, 6'b111111, rand_din(), -1, -1);
  endtask

  initial begin
    test_reset();
    test_all_chips();
    test_repeat_zero();
    test_partial_mask();
    test_start_ignored();
    test_mask_zero();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
